// File: rtl/trap_reservation_station.sv
// Reservation station feeding the trap execution unit.
//
// Dispatch writes the lowest-index free entry. Operands that are not yet
// available wait on a producer tag and snoop the CDB. Ready entries are picked
// round-robin and sent out on the issue port.
//
// Build option: define TRAP_RS_OUT_REG_EN to put an output register on the
// issue path. Otherwise the issue outputs are driven combinationally from the
// selected entry.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   input_valid/ready      dispatch handshake; control is the decoded trap op
//   op{1,2}_valid/value    operand value, valid when the value is already known
//   op{1,2}_rs_id          producer tag, used when the matching valid bit is 0
//   cdb_valid/rs_id/result common data bus broadcast
//   output_valid/ready     issue handshake to the trap execution unit
//   rs_id_out, op1, op2    issued entry tag and operand values
//   control_out            issued decoded trap op

package trap_pkg;
  typedef struct packed {
    logic [4:0] to;       // trap condition mask
    logic       is_word;  // compare low 32 bits only
  } trap_decode_t;
endpackage

module trap_reservation_station
  import trap_pkg::*;
#(
  parameter int unsigned RS_ID_WIDTH = 5,
  parameter int unsigned RS_DEPTH    = 4,
  parameter int unsigned RS_OFFSET   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  trap_decode_t           control,
  input  logic                   op1_valid,
  input  logic [31:0]            op1_value,
  input  logic [RS_ID_WIDTH-1:0] op1_rs_id,
  input  logic                   op2_valid,
  input  logic [31:0]            op2_value,
  input  logic [RS_ID_WIDTH-1:0] op2_rs_id,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [31:0]            op1,
  output logic [31:0]            op2,
  output trap_decode_t           control_out
);

  localparam int unsigned IdxW = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0]    busy_q;
  logic [RS_DEPTH-1:0]    rdy1_q, rdy2_q;
  trap_decode_t           ctrl_q [RS_DEPTH];
  logic [31:0]            val1_q [RS_DEPTH];
  logic [31:0]            val2_q [RS_DEPTH];
  logic [RS_ID_WIDTH-1:0] tag1_q [RS_DEPTH];
  logic [RS_ID_WIDTH-1:0] tag2_q [RS_DEPTH];
  logic [IdxW-1:0]        rr_ptr_q;

  logic                   dispatch;
  logic                   alloc_found;
  logic [IdxW-1:0]        alloc_idx;
  logic [RS_DEPTH-1:0]    elig;
  logic                   pick_found;
  logic [IdxW-1:0]        pick_idx;
  logic                   issue_fire;
  logic [IdxW-1:0]        issue_idx;
  logic [IdxW-1:0]        ptr_nxt;
  logic [RS_ID_WIDTH-1:0] issue_rs_id;
  logic                   byp1_hit, byp2_hit;

  assign input_ready = ~&busy_q;
  assign dispatch    = input_valid & input_ready;

  // Lowest-index free entry: scan downwards so index 0 wins.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IdxW'(i);
      end
    end
  end

  assign elig = busy_q & rdy1_q & rdy2_q;

  // Round-robin pick starting at rr_ptr_q; scan offsets downwards so the
  // smallest offset from the pointer wins.
  always_comb begin
    logic [IdxW-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = int'(RS_DEPTH) - 1; k >= 0; k--) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % int'(RS_DEPTH));
      if (elig[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Same-cycle CDB bypass for operands arriving with dispatch.
  assign byp1_hit = cdb_valid && (cdb_rs_id == op1_rs_id);
  assign byp2_hit = cdb_valid && (cdb_rs_id == op2_rs_id);

  assign ptr_nxt     = (issue_idx == IdxW'(RS_DEPTH - 1)) ? '0 : issue_idx + IdxW'(1);
  assign issue_rs_id = RS_ID_WIDTH'(RS_OFFSET + 32'(issue_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      rdy1_q   <= '0;
      rdy2_q   <= '0;
      rr_ptr_q <= '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        ctrl_q[i] <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (busy_q[i] && !rdy1_q[i] && cdb_valid && (cdb_rs_id == tag1_q[i])) begin
          rdy1_q[i] <= 1'b1;
          val1_q[i] <= cdb_result;
        end
        if (busy_q[i] && !rdy2_q[i] && cdb_valid && (cdb_rs_id == tag2_q[i])) begin
          rdy2_q[i] <= 1'b1;
          val2_q[i] <= cdb_result;
        end
        if (issue_fire && (issue_idx == IdxW'(i))) begin
          busy_q[i] <= 1'b0;
        end
        // alloc_idx only ever names a non-busy entry, so this never collides
        // with the capture or free above.
        if (dispatch && alloc_found && (alloc_idx == IdxW'(i))) begin
          busy_q[i] <= 1'b1;
          ctrl_q[i] <= control;
          rdy1_q[i] <= op1_valid | byp1_hit;
          val1_q[i] <= op1_valid ? op1_value : (byp1_hit ? cdb_result : '0);
          tag1_q[i] <= op1_rs_id;
          rdy2_q[i] <= op2_valid | byp2_hit;
          val2_q[i] <= op2_valid ? op2_value : (byp2_hit ? cdb_result : '0);
          tag2_q[i] <= op2_rs_id;
        end
      end
      if (issue_fire) begin
        rr_ptr_q <= ptr_nxt;
      end
    end
  end

`ifdef TRAP_RS_OUT_REG_EN
  logic                   out_valid_q;
  logic [RS_ID_WIDTH-1:0] out_rs_id_q;
  logic [31:0]            out_op1_q, out_op2_q;
  trap_decode_t           out_ctrl_q;

  assign issue_idx  = pick_idx;
  assign issue_fire = pick_found & (~out_valid_q | output_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_rs_id_q <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_ctrl_q  <= '0;
    end else if (issue_fire) begin
      out_valid_q <= 1'b1;
      out_rs_id_q <= issue_rs_id;
      out_op1_q   <= val1_q[issue_idx];
      out_op2_q   <= val2_q[issue_idx];
      out_ctrl_q  <= ctrl_q[issue_idx];
    end else if (output_ready) begin
      out_valid_q <= 1'b0;
      out_rs_id_q <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_ctrl_q  <= '0;
    end
  end

  assign output_valid = out_valid_q;
  assign rs_id_out    = out_rs_id_q;
  assign op1          = out_op1_q;
  assign op2          = out_op2_q;
  assign control_out  = out_ctrl_q;
`else
  // While stalled, lock onto the offered entry so a newly ready entry that
  // sits earlier in round-robin order cannot change the outputs.
  logic            hold_q;
  logic [IdxW-1:0] hold_idx_q;
  logic            out_vld;

  assign issue_idx  = hold_q ? hold_idx_q : pick_idx;
  assign out_vld    = ~rst & (hold_q | pick_found);
  assign issue_fire = out_vld & output_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      hold_q     <= out_vld & ~output_ready;
      hold_idx_q <= issue_idx;
    end
  end

  always_comb begin
    output_valid = 1'b0;
    rs_id_out    = '0;
    op1          = '0;
    op2          = '0;
    control_out  = '0;
    if (out_vld) begin
      output_valid = 1'b1;
      rs_id_out    = issue_rs_id;
      op1          = val1_q[issue_idx];
      op2          = val2_q[issue_idx];
      control_out  = ctrl_q[issue_idx];
    end
  end
`endif

endmodule

// File: tb/tb_trap_reservation_station.sv
module tb_trap_reservation_station;
  import trap_pkg::*;

`ifdef TRAP_RS_OUT_REG_EN
  localparam int Lat   = 2;
  localparam int NFill = 5;
  int exp_id [NFill] = '{0, 1, 2, 3, 0};
  int exp_k  [NFill] = '{0, 1, 3, 4, 2};
`else
  localparam int Lat   = 1;
  localparam int NFill = 4;
  int exp_id [NFill] = '{0, 1, 2, 3};
  int exp_k  [NFill] = '{0, 1, 2, 3};
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         input_valid, input_ready;
  trap_decode_t control, control_out;
  logic         op1_valid, op2_valid;
  logic [31:0]  op1_value, op2_value;
  logic [4:0]   op1_rs_id, op2_rs_id;
  logic         cdb_valid;
  logic [4:0]   cdb_rs_id;
  logic [31:0]  cdb_result;
  logic         output_valid, output_ready;
  logic [4:0]   rs_id_out;
  logic [31:0]  op1, op2;

  int n_checks = 0;
  int n_errors = 0;

  trap_reservation_station #(
    .RS_ID_WIDTH(5),
    .RS_DEPTH   (4),
    .RS_OFFSET  (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .control     (control),
    .op1_valid   (op1_valid),
    .op1_value   (op1_value),
    .op1_rs_id   (op1_rs_id),
    .op2_valid   (op2_valid),
    .op2_value   (op2_value),
    .op2_rs_id   (op2_rs_id),
    .cdb_valid   (cdb_valid),
    .cdb_rs_id   (cdb_rs_id),
    .cdb_result  (cdb_result),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .rs_id_out   (rs_id_out),
    .op1         (op1),
    .op2         (op2),
    .control_out (control_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v1, input logic [31:0] val1, input logic [4:0] t1,
                       input logic v2, input logic [31:0] val2, input logic [4:0] to);
    input_valid = 1'b1;
    op1_valid   = v1;
    op1_value   = val1;
    op1_rs_id   = t1;
    op2_valid   = v2;
    op2_value   = val2;
    op2_rs_id   = 5'd0;
    control     = '{to: to, is_word: 1'b0};
  endtask

  task automatic wait_lat();
    for (int c = 1; c < Lat; c++) begin
      check("latency_gap", output_valid, 1'b0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; input_valid = 1'b0; control = '0;
    op1_valid = 1'b0; op1_value = '0; op1_rs_id = '0;
    op2_valid = 1'b0; op2_value = '0; op2_rs_id = '0;
    cdb_valid = 1'b0; cdb_rs_id = '0; cdb_result = '0; output_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_ov_during", output_valid, 1'b0);
    rst = 1'b0;
    check("rst_in_ready", input_ready, 1'b1);
    check("rst_ov", output_valid, 1'b0);
    check("rst_rs_id", rs_id_out, 5'd0);
    check("rst_op1", op1, 32'd0);
    check("rst_op2", op2, 32'd0);
    check("rst_ctrl", control_out, 6'd0);

    // Both operands valid
    output_ready = 1'b1;
    drive(1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'b10000);
    step();
    input_valid = 1'b0;
    wait_lat();
    check("t1_ov", output_valid, 1'b1);
    check("t1_rs_id", rs_id_out, 5'd0);
    check("t1_op1", op1, 32'd5);
    check("t1_op2", op2, 32'd7);
    check("t1_ctrl", control_out, {5'b10000, 1'b0});
    step();
    check("t1_single_issue", output_valid, 1'b0);

    // op1 waits on tag 3; an unrelated CDB tag is ignored
    drive(1'b0, 32'd0, 5'd3, 1'b1, 32'd9, 5'b00100);
    step();
    input_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      check("t2_wait", output_valid, 1'b0);
      cdb_valid = (c == 2); cdb_rs_id = 5'd7; cdb_result = 32'hDEAD;
      step();
    end
    cdb_valid = 1'b0;
    check("t2_wait_last", output_valid, 1'b0);
    cdb_valid = 1'b1; cdb_rs_id = 5'd3; cdb_result = 32'hFFFF_FFFF;
    step();
    cdb_valid = 1'b0;
    wait_lat();
    check("t2_ov", output_valid, 1'b1);
    check("t2_op1", op1, 32'hFFFF_FFFF);
    check("t2_op2", op2, 32'd9);
    step();
    check("t2_done", output_valid, 1'b0);

    // Same-cycle CDB bypass on dispatch
    drive(1'b0, 32'd0, 5'd6, 1'b1, 32'h22, 5'b00010);
    cdb_valid = 1'b1; cdb_rs_id = 5'd6; cdb_result = 32'h10;
    step();
    input_valid = 1'b0; cdb_valid = 1'b0;
    wait_lat();
    check("t3_ov", output_valid, 1'b1);
    check("t3_op1", op1, 32'h10);
    check("t3_op2", op2, 32'h22);
    step();

    // Fill under backpressure, then drain in order
    rst = 1'b1;
    step();
    rst = 1'b0;
    output_ready = 1'b0;
    for (int k = 0; k < NFill; k++) begin
      drive(1'b1, 32'h100 + 32'(k), 5'd0, 1'b1, 32'h200 + 32'(k), 5'b00001);
      step();
    end
    input_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check("t4_full", input_ready, 1'b0);
      check("t4_stall_ov", output_valid, 1'b1);
      check("t4_stall_id", rs_id_out, 5'd0);
      check("t4_stall_op1", op1, 32'h100);
      check("t4_stall_op2", op2, 32'h200);
      step();
    end
    output_ready = 1'b1;
    for (int j = 0; j < NFill; j++) begin
      check("t4_ov", output_valid, 1'b1);
      check("t4_id", rs_id_out, 5'(exp_id[j]));
      check("t4_op1", op1, 32'h100 + 32'(exp_k[j]));
      if (j == 1) check("t4_in_ready", input_ready, 1'b1);
      step();
    end
    check("t4_drained", output_valid, 1'b0);

    // Round-robin: last issued 1, entries 0 and 2 become ready together
    rst = 1'b1;
    step();
    rst = 1'b0;
    output_ready = 1'b1;
    drive(1'b0, 32'd0, 5'd9, 1'b1, 32'hA2, 5'b01000);
    step();
    drive(1'b1, 32'hB1, 5'd0, 1'b1, 32'hB2, 5'b01000);
    step();
    drive(1'b0, 32'd0, 5'd9, 1'b1, 32'hC2, 5'b01000);
    if (Lat == 1) check("t5_y_id", rs_id_out, 5'd1);
    if (Lat == 1) check("t5_y_op1", op1, 32'hB1);
    step();
    input_valid = 1'b0;
    if (Lat == 2) check("t5_y_id", rs_id_out, 5'd1);
    if (Lat == 2) check("t5_y_op1", op1, 32'hB1);
    step();
    step();
    check("t5_idle", output_valid, 1'b0);
    cdb_valid = 1'b1; cdb_rs_id = 5'd9; cdb_result = 32'h99;
    step();
    cdb_valid = 1'b0;
    wait_lat();
    check("t5_first_ov", output_valid, 1'b1);
    check("t5_first_id", rs_id_out, 5'd2);
    check("t5_first_op2", op2, 32'hC2);
    step();
    check("t5_second_id", rs_id_out, 5'd0);
    check("t5_second_op1", op1, 32'h99);
    check("t5_second_op2", op2, 32'hA2);
    step();
    check("t5_done", output_valid, 1'b0);

    // Reset mid-operation discards entries and the pending output
    output_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h300 + 32'(k), 5'd0, 1'b1, 32'h400, 5'b00011);
      step();
    end
    input_valid = 1'b0;
    check("t6_pending", output_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    output_ready = 1'b1;
    check("t6_ov", output_valid, 1'b0);
    check("t6_in_ready", input_ready, 1'b1);
    check("t6_op1", op1, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t6_no_issue", output_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
